// File: rtl/sum_pkg.sv
// Shared types and defaults for the block-average controller and its adder tree.
package sum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } sum_st_t;

  localparam int SUM_W_DEF   = 8;
  localparam int SUM_N_DEF   = 4;
  localparam int SUM_AVG_DEF = 1;

  // Width of a full 2**n-sample sum of w-bit values; it can never overflow.
  function automatic int sum_w(input int w, input int n);
    return w + n;
  endfunction

endpackage

// File: rtl/sum.sv
// Pipelined binary adder tree: 2**N unsigned samples in, their sum out after N clocks.
// Heap-indexed nodes: node j adds children 2j and 2j+1; node 1 is the root.
module sum
  import sum_pkg::*;
#(
  parameter int W = SUM_W_DEF,
  parameter int N = SUM_N_DEF
) (
  input  logic                  clk,
  input  logic [W-1:0]          dat [2**N],
  output logic [sum_w(W,N)-1:0] res
);

  localparam int SW   = sum_w(W, N);
  localparam int LEAF = 2**N;

  logic [SW-1:0] node_r [1:LEAF-1];

  for (genvar j = 1; j < LEAF; j++) begin : g_node
    if (2 * j >= LEAF) begin : g_leaf
      // First stage: pairs of buffer entries, sampled on the launch edge.
      always_ff @(posedge clk) begin
        node_r[j] <= SW'(dat[2*j-LEAF]) + SW'(dat[2*j+1-LEAF]);
      end
    end else begin : g_inner
      // Later stages: pairs of partial sums from the stage below.
      always_ff @(posedge clk) begin
        node_r[j] <= node_r[2*j] + node_r[2*j+1];
      end
    end
  end

  assign res = node_r[1];

endmodule

// File: rtl/sum_avg_ctrl.sv
// Block-average controller: buffers 2**N samples, launches them into the adder
// tree, waits out its latency and holds the sum or mean until consumed.
module sum_avg_ctrl
  import sum_pkg::*;
#(
  parameter int W   = SUM_W_DEF,
  parameter int N   = SUM_N_DEF,
  parameter int AVG = SUM_AVG_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   in_dat,
  input  logic           in_val,
  output logic           in_rdy,
  input  logic           flush,
  output logic [W+N-1:0] out_dat,
  output logic           out_val,
  input  logic           out_rdy,
  output logic [N:0]     cnt,
  output logic           busy
);

  localparam int SW  = sum_w(W, N);
  localparam int BLK = 2**N;

  logic [W-1:0]  buf_r [BLK];
  logic [N:0]    cnt_r, cnt_nxt_s;
  logic          full_r, full_nxt_s, in_rdy_r;
  logic          acc_s, drain_s, launch_s, cap_s;
  sum_st_t       st_r, st_nxt_s;
  logic [N-1:0]  lat_r, lat_nxt_s;
  logic [SW-1:0] res_s, out_dat_r;
  logic          out_val_r, out_val_nxt_s, busy_r;

  // A flush drops any sample offered in the same cycle.
  assign acc_s    = in_val && in_rdy_r && !flush;
  assign drain_s  = out_val_r && out_rdy;
  assign launch_s = full_r && ((st_r == IDLE) || ((st_r == HOLD) && drain_s));

  // Fill counter and full flag; launch or flush empties the buffer.
  always_comb begin
    cnt_nxt_s  = cnt_r;
    full_nxt_s = full_r;
    if (flush || launch_s) begin
      cnt_nxt_s  = {(N+1){1'b0}};
      full_nxt_s = 1'b0;
    end else if (acc_s) begin
      cnt_nxt_s  = cnt_r + (N+1)'(1);
      full_nxt_s = (cnt_r == (N+1)'(BLK - 1));
    end else begin
      cnt_nxt_s  = cnt_r;
      full_nxt_s = full_r;
    end
  end

  // Fill-side registers; in_rdy is registered from the next full state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= {(N+1){1'b0}};
      full_r   <= 1'b0;
      in_rdy_r <= 1'b1;
    end else begin
      cnt_r    <= cnt_nxt_s;
      full_r   <= full_nxt_s;
      in_rdy_r <= !full_nxt_s;
    end
  end

  // Sample buffer; pure data, validity is tracked by cnt_r and full_r.
  always_ff @(posedge clk) begin
    if (acc_s) begin
      buf_r[cnt_r[N-1:0]] <= in_dat;
    end
  end

  sum #(.W(W), .N(N)) u_sum (
    .clk (clk),
    .dat (buf_r),
    .res (res_s)
  );

  // Output FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_r  <= IDLE;
      lat_r <= {N{1'b0}};
    end else begin
      st_r  <= st_nxt_s;
      lat_r <= lat_nxt_s;
    end
  end

  // Output FSM next state; a drain in HOLD may relaunch on the same edge.
  always_comb begin
    st_nxt_s  = st_r;
    lat_nxt_s = lat_r;
    case (st_r)
      IDLE: begin
        if (launch_s) begin
          st_nxt_s  = RUN;
          lat_nxt_s = N'(N - 1);
        end else begin
          st_nxt_s  = IDLE;
        end
      end
      RUN: begin
        if (lat_r == {N{1'b0}}) begin
          st_nxt_s  = HOLD;
        end else begin
          lat_nxt_s = lat_r - N'(1);
        end
      end
      HOLD: begin
        if (launch_s) begin
          st_nxt_s  = RUN;
          lat_nxt_s = N'(N - 1);
        end else if (drain_s) begin
          st_nxt_s  = IDLE;
        end else begin
          st_nxt_s  = HOLD;
        end
      end
      default: begin
        st_nxt_s  = IDLE;
        lat_nxt_s = {N{1'b0}};
      end
    endcase
  end

  // Output FSM decode: capture the tree result once its latency has elapsed.
  always_comb begin
    cap_s         = (st_r == RUN) && (lat_r == {N{1'b0}});
    out_val_nxt_s = out_val_r;
    if (cap_s) begin
      out_val_nxt_s = 1'b1;
    end else if (drain_s) begin
      out_val_nxt_s = 1'b0;
    end else begin
      out_val_nxt_s = out_val_r;
    end
  end

  // Output registers; out_dat only changes on capture, so it is stable in HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_val_r <= 1'b0;
      out_dat_r <= {SW{1'b0}};
      busy_r    <= 1'b0;
    end else begin
      out_val_r <= out_val_nxt_s;
      busy_r    <= (st_nxt_s != IDLE);
      if (cap_s) begin
        out_dat_r <= (AVG != 0) ? (res_s >> N) : res_s;
      end else begin
        out_dat_r <= out_dat_r;
      end
    end
  end

  assign in_rdy  = in_rdy_r;
  assign cnt     = cnt_r;
  assign out_val = out_val_r;
  assign out_dat = out_dat_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_sum_avg_ctrl.sv
// Bench for sum_avg_ctrl: mean and sum instances share one stimulus and are
// compared every cycle against a queue-based block model.
module tb_sum_avg_ctrl;

  localparam int W   = 8;
  localparam int N   = 2;
  localparam int BLK = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_dat = 8'd0;
  logic         in_val = 1'b0;
  logic         flush = 1'b0;
  logic         out_rdy = 1'b0;

  logic           in_rdy_a, in_rdy_b, out_val_a, out_val_b, busy_a, busy_b;
  logic [W+N-1:0] out_dat_a, out_dat_b;
  logic [N:0]     cnt_a, cnt_b;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sum_avg_ctrl #(.W(W), .N(N), .AVG(1)) u_mean (
    .clk(clk), .rst_n(rst_n), .in_dat(in_dat), .in_val(in_val), .in_rdy(in_rdy_a),
    .flush(flush), .out_dat(out_dat_a), .out_val(out_val_a), .out_rdy(out_rdy),
    .cnt(cnt_a), .busy(busy_a));

  sum_avg_ctrl #(.W(W), .N(N), .AVG(0)) u_sum (
    .clk(clk), .rst_n(rst_n), .in_dat(in_dat), .in_val(in_val), .in_rdy(in_rdy_b),
    .flush(flush), .out_dat(out_dat_b), .out_val(out_val_b), .out_rdy(out_rdy),
    .cnt(cnt_b), .busy(busy_b));

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a fill queue, one output slot that becomes valid N
  // edges after launch, and the queue of expected block sums.
  int fill_q[$];
  int exp_q[$];
  bit m_full = 1'b0;
  bit m_busy = 1'b0;
  bit m_valid = 1'b0;
  bit m_drain, m_launch;
  int m_age = 0;
  int m_acc = 0;
  int m_pops = 0;
  int dut_hs = 0;
  int m_sum;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q.delete();
      exp_q.delete();
      m_full  = 1'b0;
      m_busy  = 1'b0;
      m_valid = 1'b0;
      m_age   = 0;
    end else begin
      if (out_val_a && out_rdy) dut_hs++;
      m_drain  = m_valid && out_rdy;
      m_launch = m_full && (!m_busy || m_drain);
      if (m_drain) begin
        m_valid = 1'b0;
        m_busy  = 1'b0;
        void'(exp_q.pop_front());
        m_pops++;
      end
      if (m_busy && !m_valid) begin
        m_age++;
        if (m_age == N) m_valid = 1'b1;
      end
      if (m_launch) begin
        m_sum = 0;
        foreach (fill_q[i]) m_sum += fill_q[i];
        exp_q.push_back(m_sum);
        m_busy = 1'b1;
        m_age  = 0;
      end
      if (flush || m_launch) begin
        fill_q.delete();
        m_full = 1'b0;
      end else if (in_val && !m_full) begin
        fill_q.push_back(int'(in_dat));
        m_acc++;
        if (fill_q.size() == BLK) m_full = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk_eq("in_rdy", in_rdy_a, !m_full);
    chk_eq("in_rdy_b", in_rdy_b, !m_full);
    chk_eq("cnt", cnt_a, fill_q.size());
    chk_eq("cnt_b", cnt_b, fill_q.size());
    chk_eq("out_val", out_val_a, m_valid);
    chk_eq("out_val_b", out_val_b, m_valid);
    chk_eq("busy", busy_a, m_busy);
    chk_eq("busy_b", busy_b, m_busy);
    if (m_valid && exp_q.size() > 0) begin
      chk_eq("mean", out_dat_a, exp_q[0] >> N);
      chk_eq("sum", out_dat_b, exp_q[0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    bit ok;
    in_dat = v[W-1:0];
    in_val = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      ok = in_rdy_a;
      tick();
    end
    in_val = 1'b0;
    chk_eq("send_acc", ok, 1);
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_val_a && cyc < 50) begin
      tick();
      cyc++;
    end
    chk_eq("out_seen", out_val_a, 1);
  endtask

  initial begin
    int cyc;
    int acc0;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_in_rdy", in_rdy_a, 1);
    chk_eq("rst_out_val", out_val_a, 0);
    chk_eq("rst_out_dat", out_dat_a, 0);
    chk_eq("rst_cnt", cnt_a, 0);
    chk_eq("rst_busy", busy_a, 0);
    rst_n = 1'b1;
    tick();

    // Small mean, exact latency, single-cycle valid.
    out_rdy = 1'b1;
    for (int i = 1; i <= 4; i++) send(i);
    wait_out(cyc);
    chk_eq("lat1", cyc, N + 1);
    chk_eq("mean1", out_dat_a, 2);
    chk_eq("sum1", out_dat_b, 10);
    tick();
    chk_eq("pulse1", out_val_a, 0);

    // Full-scale block: no overflow.
    for (int i = 0; i < 4; i++) send(255);
    wait_out(cyc);
    chk_eq("sum_max", out_dat_b, 1020);
    chk_eq("mean_max", out_dat_a, 255);
    tick();

    // Consumer stalled: first result held, second block waits full.
    out_rdy = 1'b0;
    for (int i = 0; i < 8; i++) send(int'($urandom_range(0, 255)));
    repeat (20) tick();
    chk_eq("hold_val", out_val_a, 1);
    chk_eq("hold_cnt", cnt_a, 4);
    chk_eq("hold_rdy", in_rdy_a, 0);
    out_rdy = 1'b1;
    tick();
    chk_eq("b2b_busy", busy_a, 1);
    chk_eq("b2b_rdy", in_rdy_a, 1);
    chk_eq("b2b_cnt", cnt_a, 0);
    wait_out(cyc);
    chk_eq("lat2", cyc, N);
    tick();

    // Flush with a simultaneous sample: both are discarded.
    send(7);
    send(9);
    in_dat = 8'd33;
    in_val = 1'b1;
    flush = 1'b1;
    tick();
    in_val = 1'b0;
    flush = 1'b0;
    chk_eq("flush_cnt", cnt_a, 0);
    for (int i = 0; i < 4; i++) send(4);
    wait_out(cyc);
    chk_eq("flush_mean", out_dat_a, 4);
    chk_eq("flush_sum", out_dat_b, 16);
    tick();

    // Asynchronous reset while a block is in the tree.
    for (int i = 5; i <= 8; i++) send(i);
    tick();
    tick();
    chk_eq("run_busy", busy_a, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("arst_out_val", out_val_a, 0);
    chk_eq("arst_busy", busy_a, 0);
    chk_eq("arst_in_rdy", in_rdy_a, 1);
    chk_eq("arst_cnt", cnt_a, 0);
    chk_eq("arst_out_dat", out_dat_a, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_eq("post_rst_quiet", out_val_a, 0);
    end
    for (int i = 0; i < 4; i++) send(1);
    wait_out(cyc);
    chk_eq("post_rst_mean", out_dat_a, 1);
    tick();

    // Random stream with random back-pressure and rare flushes.
    acc0 = m_acc;
    cyc = 0;
    while ((m_acc - acc0) < 1000 && cyc < 20000) begin
      in_val  = ($urandom_range(0, 3) != 0);
      in_dat  = 8'($urandom);
      out_rdy = $urandom_range(0, 1) == 1;
      flush   = ($urandom_range(0, 99) == 0);
      tick();
      cyc++;
    end
    in_val  = 1'b0;
    flush   = 1'b0;
    out_rdy = 1'b1;
    repeat (20) tick();
    chk_eq("rand_accepts", ((m_acc - acc0) >= 1000) ? 1 : 0, 1);
    chk_eq("rand_drained", out_val_a, 0);
    chk_eq("rand_blocks", dut_hs, m_pops);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
